// File: rtl/int_arbiter.sv
// Prioritised interrupt controller: per-source edge capture into a pending register,
// software mask, fixed-priority select and a REQ/ack/eret handshake to the CPU.

module int_src_cap (
  input  logic clk,
  input  logic RSTN,
  input  logic src,
  input  logic clr,
  output logic pend
);
  logic irq_q;

  // New edge wins over a same-cycle clear.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      irq_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_q <= src;
      pend  <= (pend & ~clr) | (src & ~irq_q);
    end
  end
endmodule

module int_arbiter #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             INT,
  output logic [ID_W-1:0]  int_id,
  input  logic             int_ack,
  input  logic             eret,
  output logic             in_service
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [N_SRC-1:0] mask, pending, act, clr, ack_clr;
  logic [ID_W-1:0]  sel, cur_id, cur_id_d, int_id_d;
  logic             act_any, int_d, svc_d, ack_fire;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:N_SRC];

  genvar g;
  generate
    for (g = 0; g < N_SRC; g++) begin : g_src
      int_src_cap u_cap (
        .clk  (clk),
        .RSTN (RSTN),
        .src  (irq_src[g]),
        .clr  (clr[g]),
        .pend (pending[g])
      );
    end
  endgenerate

  assign act     = pending & mask;
  assign act_any = |act;

  // Scan high to low so the lowest active index ends up selected.
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (act[i]) sel = ID_W'(i);
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_SRC; i++)
      ack_clr[i] = ack_fire && (int_id == ID_W'(i));
  end

  assign clr = ack_clr | ((we && addr == 2'd1) ? wdata[N_SRC-1:0] : '0);

  always_comb begin
    state_d  = state;
    int_d    = INT;
    int_id_d = int_id;
    cur_id_d = cur_id;
    svc_d    = in_service;
    ack_fire = 1'b0;
    case (state)
      IDLE: if (act_any) begin
        state_d  = REQ;
        int_d    = 1'b1;
        int_id_d = sel;
      end
      REQ: begin
        if (!act_any) begin
          state_d = IDLE;
          int_d   = 1'b0;
        end else if (int_ack) begin
          state_d  = SERVICE;
          int_d    = 1'b0;
          svc_d    = 1'b1;
          cur_id_d = int_id;
          ack_fire = 1'b1;
        end else begin
          int_id_d = sel;
        end
      end
      SERVICE: if (eret) begin
        state_d = IDLE;
        svc_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        int_d   = 1'b0;
        svc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      INT        <= 1'b0;
      int_id     <= '0;
      cur_id     <= '0;
      in_service <= 1'b0;
      mask       <= '0;
    end else begin
      state      <= state_d;
      INT        <= int_d;
      int_id     <= int_id_d;
      cur_id     <= cur_id_d;
      in_service <= svc_d;
      if (we && addr == 2'd0) mask <= wdata[N_SRC-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata = 32'(mask);
      2'd1: rdata = 32'(pending);
      2'd2: rdata = {27'b0, state, in_service, INT, 1'b0};
      2'd3: rdata = 32'(cur_id);
      default: rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_int_arbiter.sv
// Table-driven bench for int_arbiter: each row drives one cycle of inputs and
// carries the outputs expected just after that cycle's rising edge.

module tb_int_arbiter;
  logic        clk, RSTN;
  logic [3:0]  irq_src;
  logic        we, int_ack, eret;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic        INT, in_service;
  logic [2:0]  int_id;

  int_arbiter #(.N_SRC(4), .ID_W(3)) dut (
    .clk        (clk),
    .RSTN       (RSTN),
    .irq_src    (irq_src),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .INT        (INT),
    .int_id     (int_id),
    .int_ack    (int_ack),
    .eret       (eret),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        eret;
    logic        e_int;
    logic [2:0]  e_id;
    logic        e_svc;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl[NV];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [3:0] irq, input logic w, input logic [1:0] a,
                              input logic [31:0] wd, input logic ak, input logic er,
                              input logic ei, input logic [2:0] eid, input logic es,
                              input logic [31:0] erd);
    vec_t v;
    v.irq = irq; v.we = w; v.addr = a; v.wdata = wd; v.ack = ak; v.eret = er;
    v.e_int = ei; v.e_id = eid; v.e_svc = es; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    irq_src = v.irq; we = v.we; addr = v.addr; wdata = v.wdata;
    int_ack = v.ack; eret = v.eret;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d INT", idx), 32'(INT), 32'(e.e_int));
    if (e.e_int) chk($sformatf("v%0d int_id", idx), 32'(int_id), 32'(e.e_id));
    chk($sformatf("v%0d in_service", idx), 32'(in_service), 32'(e.e_svc));
    chk($sformatf("v%0d rdata", idx), rdata, e.e_rd);
  endtask

  initial begin
    //            irq we a  wdata ack eret | INT id svc rdata
    tbl[0]  = mk(4'h0, 1, 0, 32'hF, 0, 0,   0, 0, 0, 32'hF);
    tbl[1]  = mk(4'h4, 0, 1, 32'h0, 0, 0,   0, 0, 0, 32'h4);
    tbl[2]  = mk(4'h4, 0, 2, 32'h0, 0, 0,   1, 2, 0, 32'hA);
    tbl[3]  = mk(4'h4, 0, 1, 32'h0, 0, 0,   1, 2, 0, 32'h4);
    tbl[4]  = mk(4'h1, 0, 1, 32'h0, 0, 0,   1, 2, 0, 32'h5);
    tbl[5]  = mk(4'h1, 0, 3, 32'h0, 0, 0,   1, 0, 0, 32'h0);
    tbl[6]  = mk(4'h1, 0, 3, 32'h0, 1, 0,   0, 0, 1, 32'h0);
    tbl[7]  = mk(4'h1, 0, 1, 32'h0, 0, 0,   0, 0, 1, 32'h4);
    tbl[8]  = mk(4'h1, 0, 2, 32'h0, 0, 0,   0, 0, 1, 32'h14);
    tbl[9]  = mk(4'h3, 0, 1, 32'h0, 0, 0,   0, 0, 1, 32'h6);
    tbl[10] = mk(4'h3, 0, 2, 32'h0, 0, 1,   0, 0, 0, 32'h0);
    tbl[11] = mk(4'h3, 0, 2, 32'h0, 0, 0,   1, 1, 0, 32'hA);
    tbl[12] = mk(4'h3, 0, 3, 32'h0, 1, 0,   0, 0, 1, 32'h1);
    tbl[13] = mk(4'h0, 0, 1, 32'h0, 0, 1,   0, 0, 0, 32'h4);
    tbl[14] = mk(4'h0, 0, 2, 32'h0, 0, 0,   1, 2, 0, 32'hA);
    tbl[15] = mk(4'h0, 0, 3, 32'h0, 1, 0,   0, 0, 1, 32'h2);
    tbl[16] = mk(4'h0, 0, 1, 32'h0, 0, 1,   0, 0, 0, 32'h0);
    tbl[17] = mk(4'h0, 1, 0, 32'h0, 0, 0,   0, 0, 0, 32'h0);
    tbl[18] = mk(4'h8, 0, 1, 32'h0, 0, 0,   0, 0, 0, 32'h8);
    tbl[19] = mk(4'h8, 0, 2, 32'h0, 0, 0,   0, 0, 0, 32'h0);
    tbl[20] = mk(4'h8, 1, 0, 32'h8, 0, 0,   0, 0, 0, 32'h8);
    tbl[21] = mk(4'h8, 0, 2, 32'h0, 0, 0,   1, 3, 0, 32'hA);
    tbl[22] = mk(4'h8, 1, 1, 32'h8, 0, 0,   1, 3, 0, 32'h0);
    tbl[23] = mk(4'h8, 0, 2, 32'h0, 0, 0,   0, 0, 0, 32'h0);
    tbl[24] = mk(4'h0, 1, 0, 32'hF, 0, 0,   0, 0, 0, 32'hF);
    tbl[25] = mk(4'h2, 0, 1, 32'h0, 0, 0,   0, 0, 0, 32'h2);
    tbl[26] = mk(4'h0, 0, 2, 32'h0, 0, 0,   1, 1, 0, 32'hA);
    tbl[27] = mk(4'h2, 1, 1, 32'h2, 0, 0,   1, 1, 0, 32'h2);
    tbl[28] = mk(4'h0, 0, 2, 32'h0, 0, 1,   1, 1, 0, 32'hA);
    tbl[29] = mk(4'h0, 1, 1, 32'h2, 0, 0,   1, 1, 0, 32'h0);
    tbl[30] = mk(4'h0, 0, 2, 32'h0, 0, 0,   0, 0, 0, 32'h0);
    tbl[31] = mk(4'h0, 0, 2, 32'h0, 1, 0,   0, 0, 0, 32'h0);
    tbl[32] = mk(4'h1, 0, 1, 32'h0, 0, 0,   0, 0, 0, 32'h1);
    tbl[33] = mk(4'h0, 0, 2, 32'h0, 0, 0,   1, 0, 0, 32'hA);
    tbl[34] = mk(4'h0, 0, 2, 32'h0, 1, 1,   0, 0, 1, 32'h14);

    RSTN = 1'b0; irq_src = '0; we = 1'b0; addr = 2'd0; wdata = '0;
    int_ack = 1'b0; eret = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst INT", 32'(INT), 32'h0);
    chk("rst in_service", 32'(in_service), 32'h0);
    chk("rst MASK", rdata, 32'h0);
    addr = 2'd2; #1;
    chk("rst STATUS", rdata, 32'h0);
    addr = 2'd3; #1;
    chk("rst CUR_ID", rdata, 32'h0);
    @(negedge clk);
    RSTN = 1'b1;

    for (int i = 0; i < NV; i++) step(tbl[i], i);

    // Now in SERVICE with MASK=0xF; leave a pending edge, then reset mid-cycle.
    @(negedge clk);
    irq_src = 4'h4; we = 1'b0; addr = 2'd1; int_ack = 1'b0; eret = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-rst PENDING", rdata, 32'h4);
    chk("pre-rst in_service", 32'(in_service), 32'h1);
    RSTN = 1'b0;
    #1;
    chk("async INT", 32'(INT), 32'h0);
    chk("async in_service", 32'(in_service), 32'h0);
    chk("async PENDING", rdata, 32'h0);
    addr = 2'd0; #1;
    chk("async MASK", rdata, 32'h0);
    addr = 2'd2; #1;
    chk("async STATUS", rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/int_arbiter.md
Name: int_arbiter

Overview:
- Prioritised interrupt controller between the timer/peripheral interrupt sources (counter0/1/2 outputs, button pulses) and the pipelined CPU's single INT input.
- Captures rising edges into a pending register and applies a software-written mask.
- Presents one request with a source ID to the CPU and sequences the request, acknowledge and return handshake, so only one interrupt is in service at a time.
- Memory-mapped on the MIO bus with 4 word registers.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8); index 0 is the highest priority.
- ID_W, 3, width of the source ID field.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- RSTN  in  1  asynchronous active-low reset.
- irq_src  in  N_SRC  raw source levels, already synchronous to clk.
- we  in  1  bus write strobe.
- addr  in  2  word select: 0=MASK, 1=PENDING, 2=STATUS, 3=CUR_ID.
- wdata  in  32  bus write data.
- rdata  out  32  combinational read data for addr.
- INT  out  1  interrupt request to the CPU (registered).
- int_id  out  ID_W  ID of the requested source, valid while INT=1.
- int_ack  in  1  one-cycle pulse from the CPU on exception entry.
- eret  in  1  one-cycle pulse from the CPU on return from handler.
- in_service  out  1  high between accepted ack and eret.

Behaviour:
- Reset (RSTN=0, asynchronous): mask=0, pending=0, irq_q=0, state=IDLE, INT=0, int_id=0, cur_id=0, in_service=0.
- Edge capture: irq_q <= irq_src every cycle; pending[i] sets on the edge where irq_src[i]=1 and irq_q[i]=0.
  - A level held high does not re-trigger.
  - A source high at reset release counts as one edge.
- Active set: act = pending & mask[N_SRC-1:0]; sel = lowest set index of act (fixed priority).
- States (2-bit):
  - IDLE: INT=0. If act!=0, go to REQ; INT<=1, int_id<=sel.
  - REQ: INT=1; int_id re-registers sel each cycle, so a newly arrived higher-priority source replaces the ID before ack.
    - If act becomes 0 (masked or cleared by software), go to IDLE; INT<=0.
    - On int_ack: cur_id<=int_id, clear pending[int_id], go to SERVICE; INT<=0, in_service<=1.
  - SERVICE: INT=0; new edges keep accumulating in pending; no nesting.
    - On eret: go to IDLE; in_service<=0. If act!=0, IDLE immediately moves to REQ on the next edge.
  - int_ack outside REQ and eret outside SERVICE are ignored.
  - int_ack and eret in the same cycle: only the one legal for the current state acts.
- Latency:
  - Source rises before edge k: pending set at k, INT high after k+1 (2 clocks).
  - Ack at edge m: INT low after m.
  - Eret at edge e with remaining act: INT high after e+1.
- Registers:
  - MASK (0): RW, bits [N_SRC-1:0]; upper bits read 0.
  - PENDING (1): read returns pending. Write is write-1-to-clear. If a new edge sets the same bit in the same cycle as a clear, set wins.
  - STATUS (2): RO; {27'b0, state[1:0], in_service, INT, 1'b0}, i.e. state at bits [4:3], in_service at bit 2, INT at bit 1.
  - CUR_ID (3): RO; zero-extended cur_id.
  - Writes to RO addresses are ignored.
  - A bus write and a state transition in the same cycle both take effect; the write is visible in act on the following cycle.
- Reset mid-operation (any state) returns to the IDLE reset values immediately; a pending interrupt is lost.

Test Plan:
- Reset, then MASK=0xF, pulse irq_src[2] high 3 cycles -> PENDING=0x4 one cycle after the rise; INT=1 and int_id=2 one cycle later; INT stays 1 until ack; irq_src held high gives no second set.
- In REQ for source 2, raise irq_src[0] before ack -> int_id changes to 0 on the next edge; int_ack -> CUR_ID=0, PENDING=0x4, STATUS state=SERVICE, in_service=1.
- In SERVICE raise irq_src[1]; eret -> IDLE for one cycle, then INT=1 with int_id=1 (the pending 2 waits behind 1); ack, eret, then INT=1 with int_id=2.
- MASK=0x0 with irq_src[3] edge -> PENDING=0x8, INT stays 0; write MASK=0x8 -> INT=1 two edges later; write PENDING=0x8 (W1C) while in REQ -> INT returns to 0 and state to IDLE.
- W1C of bit 1 in the same cycle as a new irq_src[1] edge -> PENDING bit1 stays 1; int_ack while IDLE and eret while REQ -> no state change.
- Assert RSTN=0 mid-cycle while in SERVICE -> INT, in_service, PENDING and MASK go to 0 without waiting for a clock edge.
